// File: rtl/load_store_unit.sv
// Load/store unit: classifies one request at a time, drives a single word-aligned
// byte-enabled memory transaction and returns extended load data or an error cause.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] address,
  input  logic [31:0] datawr,
  input  logic        dmwr,
  input  logic [2:0]  dmctrl,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        resp_valid,
  output logic [1:0]  resp_err,
  output logic [31:0] datard
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;
  localparam logic [7:0] CNT_LAST    = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [1:0]  lane_reg, lane_next;
  logic [2:0]  ctrl_reg, ctrl_next;
  logic        req_ready_reg, req_ready_next;
  logic        mem_req_reg, mem_req_next;
  logic        mem_we_reg, mem_we_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [3:0]  mem_be_reg, mem_be_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;
  logic        resp_valid_reg, resp_valid_next;
  logic [1:0]  resp_err_reg, resp_err_next;
  logic [31:0] datard_reg, datard_next;

  logic        illegal, misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] rd_shifted;
  logic [31:0] rd_ext;

  // Request decode straight from the execute-stage inputs, used on the accept edge.
  always_comb begin
    illegal    = (dmctrl == 3'b011) || (dmctrl[2:1] == 2'b11) || (dmwr && dmctrl[2]);
    misaligned = ((dmctrl[1:0] == 2'b01) && address[0]) ||
                 ((dmctrl == 3'b010) && (address[1:0] != 2'b00));
    case (dmctrl[1:0])
      2'b00:   be_calc = 4'b0001 << address[1:0];
      2'b01:   be_calc = 4'b0011 << address[1:0];
      default: be_calc = 4'b1111;
    endcase
    if (!dmwr) begin
      wdata_calc = 32'h0;
    end else begin
      case (dmctrl[1:0])
        2'b00:   wdata_calc = {4{datawr[7:0]}};
        2'b01:   wdata_calc = {2{datawr[15:0]}};
        default: wdata_calc = datawr;
      endcase
    end
  end

  always_comb begin
    rd_shifted = mem_rdata >> {lane_reg, 3'b000};
    case (ctrl_reg)
      3'b000:  rd_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b001:  rd_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b100:  rd_ext = {24'h0, rd_shifted[7:0]};
      3'b101:  rd_ext = {16'h0, rd_shifted[15:0]};
      default: rd_ext = rd_shifted;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    lane_next       = lane_reg;
    ctrl_next       = ctrl_reg;
    mem_req_next    = mem_req_reg;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_be_next     = mem_be_reg;
    mem_wdata_next  = mem_wdata_reg;
    resp_valid_next = 1'b0;
    resp_err_next   = ERR_OK;
    datard_next     = datard_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          lane_next = address[1:0];
          ctrl_next = dmctrl;
          cnt_next  = 8'h0;
          if (illegal) begin
            state_next      = ERR;
            resp_valid_next = 1'b1;
            resp_err_next   = ERR_ILLEGAL;
            datard_next     = 32'h0;
          end else if (misaligned) begin
            state_next      = ERR;
            resp_valid_next = 1'b1;
            resp_err_next   = ERR_ALIGN;
            datard_next     = 32'h0;
          end else begin
            state_next     = WAIT;
            mem_req_next   = 1'b1;
            mem_we_next    = dmwr;
            mem_addr_next  = {address[31:2], 2'b00};
            mem_be_next    = be_calc;
            mem_wdata_next = wdata_calc;
          end
        end
      end
      WAIT: begin
        // An ack in the final timeout cycle still completes normally.
        if (mem_ack || (cnt_reg == CNT_LAST)) begin
          mem_req_next    = 1'b0;
          mem_we_next     = 1'b0;
          mem_addr_next   = 32'h0;
          mem_be_next     = 4'h0;
          mem_wdata_next  = 32'h0;
          resp_valid_next = 1'b1;
          if (mem_ack) begin
            state_next  = DONE;
            datard_next = mem_we_reg ? 32'h0 : rd_ext;
          end else begin
            state_next    = ERR;
            resp_err_next = ERR_TIMEOUT;
            datard_next   = 32'h0;
          end
        end else begin
          cnt_next = cnt_reg + 8'h1;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    req_ready_next = (state_next == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= 8'h0;
      lane_reg       <= 2'b00;
      ctrl_reg       <= 3'b000;
      req_ready_reg  <= 1'b1;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= 32'h0;
      mem_be_reg     <= 4'h0;
      mem_wdata_reg  <= 32'h0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= ERR_OK;
      datard_reg     <= 32'h0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      lane_reg       <= lane_next;
      ctrl_reg       <= ctrl_next;
      req_ready_reg  <= req_ready_next;
      mem_req_reg    <= mem_req_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_be_reg     <= mem_be_next;
      mem_wdata_reg  <= mem_wdata_next;
      resp_valid_reg <= resp_valid_next;
      resp_err_reg   <= resp_err_next;
      datard_reg     <= datard_next;
    end
  end

  assign req_ready  = req_ready_reg;
  assign mem_req    = mem_req_reg;
  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_be     = mem_be_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_err   = resp_err_reg;
  assign datard     = datard_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, error causes, timeout and reset abort.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] address = 32'h0;
  logic [31:0] datawr = 32'h0;
  logic        dmwr = 1'b0;
  logic [2:0]  dmctrl = 3'b000;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic        resp_valid;
  logic [1:0]  resp_err;
  logic [31:0] datard;

  int total = 0;
  int bad = 0;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .address(address), .datawr(datawr), .dmwr(dmwr), .dmctrl(dmctrl),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .resp_valid(resp_valid), .resp_err(resp_err), .datard(datard)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one accept edge; returns in cycle t0+1.
  task automatic start_req(input logic [31:0] a, input logic [31:0] d,
                           input logic wr, input logic [2:0] c);
    address = a; datawr = d; dmwr = wr; dmctrl = c; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(); step();
    total++;
    if ({req_ready, mem_req, mem_we, resp_valid, mem_be, resp_err} !== 10'b1000_0000_00) begin
      bad++;
      $display("FAIL reset_ctrl got rdy=%b req=%b we=%b rv=%b be=%b err=%b want 1 0 0 0 0000 00",
               req_ready, mem_req, mem_we, resp_valid, mem_be, resp_err);
    end
    total++;
    if ({mem_addr, mem_wdata, datard} !== 96'h0) begin
      bad++;
      $display("FAIL reset_data got addr=%h wdata=%h datard=%h want all 0", mem_addr, mem_wdata, datard);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_loads;
    logic [31:0] la [0:5];
    logic [2:0]  lc [0:5];
    logic [31:0] lr [0:5];
    logic [3:0]  lb [0:5];
    logic [31:0] le [0:5];
    la = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h204, 32'h101};
    lc = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010, 3'b000};
    lr = '{32'h80FF1234, 32'h80FF1234, 32'h9ABC0000, 32'h9ABC0000, 32'h12345678, 32'h00007F00};
    lb = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1111, 4'b0010};
    le = '{32'hFFFFFF80, 32'h00000080, 32'h00009ABC, 32'hFFFF9ABC, 32'h12345678, 32'h0000007F};
    for (int i = 0; i < 6; i++) begin
      start_req(la[i], 32'hFFFFFFFF, 1'b0, lc[i]);
      total++;
      if ({mem_req, mem_we, req_ready, resp_valid} !== 4'b1000 || mem_addr !== {la[i][31:2], 2'b00}
          || mem_be !== lb[i] || mem_wdata !== 32'h0) begin
        bad++;
        $display("FAIL load%0d_issue got req=%b we=%b rdy=%b rv=%b addr=%h be=%b wdata=%h want 1 0 0 0 %h %b 0",
                 i, mem_req, mem_we, req_ready, resp_valid, mem_addr, mem_be, mem_wdata,
                 {la[i][31:2], 2'b00}, lb[i]);
      end
      mem_ack = 1'b1; mem_rdata = lr[i];
      step();
      mem_ack = 1'b0; mem_rdata = 32'h5A5A5A5A;
      total++;
      if (resp_valid !== 1'b1 || resp_err !== 2'b00 || datard !== le[i] || mem_req !== 1'b0) begin
        bad++;
        $display("FAIL load%0d_resp got rv=%b err=%b datard=%h req=%b want 1 00 %h 0",
                 i, resp_valid, resp_err, datard, mem_req, le[i]);
      end
      step();
      total++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        bad++;
        $display("FAIL load%0d_idle got rv=%b rdy=%b want 0 1", i, resp_valid, req_ready);
      end
      $display("load %0d addr=%h ctrl=%b datard=%h", i, la[i], lc[i], datard);
    end
  endtask

  task automatic test_stores;
    logic [31:0] sa [0:2];
    logic [31:0] sd [0:2];
    logic [2:0]  sc [0:2];
    logic [3:0]  sb [0:2];
    logic [31:0] sw [0:2];
    sa = '{32'h102, 32'h101, 32'h104};
    sd = '{32'h1234ABCD, 32'h00000055, 32'hDEADBEEF};
    sc = '{3'b001, 3'b000, 3'b010};
    sb = '{4'b1100, 4'b0010, 4'b1111};
    sw = '{32'hABCDABCD, 32'h55555555, 32'hDEADBEEF};
    for (int i = 0; i < 3; i++) begin
      start_req(sa[i], sd[i], 1'b1, sc[i]);
      total++;
      if ({mem_req, mem_we} !== 2'b11 || mem_addr !== {sa[i][31:2], 2'b00}
          || mem_be !== sb[i] || mem_wdata !== sw[i]) begin
        bad++;
        $display("FAIL store%0d_issue got req=%b we=%b addr=%h be=%b wdata=%h want 1 1 %h %b %h",
                 i, mem_req, mem_we, mem_addr, mem_be, mem_wdata, {sa[i][31:2], 2'b00}, sb[i], sw[i]);
      end
      mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
      step();
      mem_ack = 1'b0;
      total++;
      if (resp_valid !== 1'b1 || resp_err !== 2'b00 || datard !== 32'h0 || mem_req !== 1'b0) begin
        bad++;
        $display("FAIL store%0d_resp got rv=%b err=%b datard=%h req=%b want 1 00 0 0",
                 i, resp_valid, resp_err, datard, mem_req);
      end
      step();
      $display("store %0d addr=%h be=%b wdata=%h", i, sa[i], sb[i], sw[i]);
    end
  endtask

  task automatic test_errors;
    logic [31:0] ea [0:5];
    logic        ew [0:5];
    logic [2:0]  ec [0:5];
    logic [1:0]  ee [0:5];
    ea = '{32'h101, 32'h103, 32'h100, 32'h101, 32'h100, 32'h102};
    ew = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ec = '{3'b010, 3'b001, 3'b100, 3'b011, 3'b110, 3'b101};
    ee = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
    for (int i = 0; i < 6; i++) begin
      start_req(ea[i], 32'h11223344, ew[i], ec[i]);
      total++;
      if (resp_valid !== 1'b1 || resp_err !== ee[i] || mem_req !== 1'b0 || datard !== 32'h0) begin
        bad++;
        $display("FAIL err%0d_resp got rv=%b err=%b req=%b datard=%h want 1 %b 0 0",
                 i, resp_valid, resp_err, mem_req, datard, ee[i]);
      end
      step();
      total++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req !== 1'b0) begin
        bad++;
        $display("FAIL err%0d_idle got rv=%b rdy=%b req=%b want 0 1 0", i, resp_valid, req_ready, mem_req);
      end
      $display("error %0d addr=%h wr=%b ctrl=%b err=%b", i, ea[i], ew[i], ec[i], ee[i]);
    end
  endtask

  task automatic test_timeout;
    start_req(32'h300, 32'h0, 1'b0, 3'b010);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem_req !== 1'b1 || resp_valid !== 1'b0) begin
        bad++;
        $display("FAIL tmo_wait%0d got req=%b rv=%b want 1 0", i, mem_req, resp_valid);
      end
      step();
    end
    total++;
    if (resp_valid !== 1'b1 || resp_err !== 2'b11 || mem_req !== 1'b0 || datard !== 32'h0) begin
      bad++;
      $display("FAIL tmo_resp got rv=%b err=%b req=%b datard=%h want 1 11 0 0",
               resp_valid, resp_err, mem_req, datard);
    end
    step();
    $display("timeout load addr=300 err=%b", 2'b11);
    start_req(32'h300, 32'h0, 1'b0, 3'b010);
    for (int i = 0; i < 3; i++) step();
    total++;
    if (mem_req !== 1'b1) begin
      bad++;
      $display("FAIL late_ack_req got req=%b want 1", mem_req);
    end
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 1'b0;
    total++;
    if (resp_valid !== 1'b1 || resp_err !== 2'b00 || datard !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL late_ack_resp got rv=%b err=%b datard=%h want 1 00 cafef00d", resp_valid, resp_err, datard);
    end
    step();
    $display("late ack load addr=300 datard=%h", datard);
  endtask

  task automatic test_reset_mid;
    start_req(32'h200, 32'h0, 1'b0, 3'b010);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (mem_req !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid got req=%b rdy=%b rv=%b want 0 1 0", mem_req, req_ready, resp_valid);
    end
    step();
    total++;
    if (resp_valid !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_quiet got rv=%b req=%b want 0 0", resp_valid, mem_req);
    end
    start_req(32'h200, 32'h0, 1'b0, 3'b010);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200 || mem_be !== 4'b1111) begin
      bad++;
      $display("FAIL rst_lw_issue got req=%b addr=%h be=%b want 1 00000200 1111", mem_req, mem_addr, mem_be);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0BADBEEF;
    step();
    mem_ack = 1'b0;
    total++;
    if (resp_valid !== 1'b1 || resp_err !== 2'b00 || datard !== 32'h0BADBEEF) begin
      bad++;
      $display("FAIL rst_lw_resp got rv=%b err=%b datard=%h want 1 00 0badbeef", resp_valid, resp_err, datard);
    end
    step();
    $display("reset abort then lw addr=200 datard=%h", datard);
  endtask

  task automatic test_back_to_back;
    // A request raised while busy must be dropped, not queued.
    start_req(32'h400, 32'h0, 1'b0, 3'b100);
    address = 32'h500; datawr = 32'h99; dmwr = 1'b1; dmctrl = 3'b010; req_valid = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h000000F0;
    step();
    req_valid = 1'b0; mem_ack = 1'b0;
    total++;
    if (resp_valid !== 1'b1 || datard !== 32'h000000F0) begin
      bad++;
      $display("FAIL busy_resp got rv=%b datard=%h want 1 000000f0", resp_valid, datard);
    end
    step();
    step();
    total++;
    if (mem_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL busy_ignored got req=%b rv=%b rdy=%b want 0 0 1", mem_req, resp_valid, req_ready);
    end
    $display("busy request ignored, load datard=%h", datard);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
